// File: rtl/lcd_pkg.sv
// Shared encodings and sizes for the LCD host and its image buffer.
package lcd_pkg;

    localparam int DW      = 8;
    localparam int IMG_PIX = 36;
    localparam int WIN_PIX = 9;

    localparam logic [2:0] CMD_REFLASH = 3'd0;
    localparam logic [2:0] CMD_LOAD    = 3'd1;
    localparam logic [2:0] CMD_RIGHT   = 3'd2;
    localparam logic [2:0] CMD_LEFT    = 3'd3;
    localparam logic [2:0] CMD_UP      = 3'd4;
    localparam logic [2:0] CMD_DOWN    = 3'd5;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FILL     = 3'd1,
        ISSUE    = 3'd2,
        STREAM   = 3'd3,
        WAIT_OUT = 3'd4,
        DONE     = 3'd5
    } host_state_e;

    // Encodings 6 and 7 have no controller meaning.
    function automatic logic op_is_valid(input logic [2:0] op);
        return (op <= CMD_DOWN);
    endfunction

endpackage

// File: rtl/lcd_host_imgbuf.sv
// 36-entry pixel register file: written in raster order during FILL, read by index during STREAM.
module lcd_host_imgbuf
    import lcd_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          i_we,
    input  logic [5:0]    i_waddr,
    input  logic [DW-1:0] i_wdata,
    input  logic [5:0]    i_raddr,
    output logic [DW-1:0] o_rdata
);

    logic [DW-1:0] r_mem [IMG_PIX];

    // Pixel storage; out-of-range addresses are ignored on write and read back as zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < IMG_PIX; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && (i_waddr < 6'(IMG_PIX))) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = (i_raddr < 6'(IMG_PIX)) ? r_mem[i_raddr] : '0;

endmodule

// File: rtl/lcd_host.sv
// Initiator side of the LCD controller cmd/datain/dataout/busy protocol.
// Buffers a Load image, issues commands, streams pixels and packs the returned 9-byte window.
module lcd_host
    import lcd_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  op_valid,
    output logic                  op_ready,
    input  logic [2:0]            op_cmd,
    input  logic                  px_valid,
    output logic                  px_ready,
    input  logic [DW-1:0]         px_data,
    output logic                  win_valid,
    input  logic                  win_ready,
    output logic [DW*WIN_PIX-1:0] win_data,
    output logic                  err,
    output logic [2:0]            lcd_cmd,
    output logic                  lcd_cmd_valid,
    output logic [DW-1:0]         lcd_datain,
    input  logic [DW-1:0]         lcd_dataout,
    input  logic                  lcd_output_valid,
    input  logic                  lcd_busy
);

    localparam logic [5:0] PIX_LAST  = 6'(IMG_PIX - 1);
    localparam logic [5:0] PIX_END   = 6'(IMG_PIX);
    localparam logic [3:0] OUT_LAST  = 4'(WIN_PIX - 1);
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    host_state_e           r_state;
    host_state_e           w_next;
    logic [2:0]            r_cmd;
    logic [5:0]            r_pix_cnt;
    logic [3:0]            r_out_cnt;
    logic [7:0]            r_wait;
    logic [DW-1:0]         r_datain;
    logic [DW*WIN_PIX-1:0] r_win;
    logic                  r_win_valid;
    logic                  r_err;

    logic                  w_op_fire;
    logic                  w_px_fire;
    logic                  w_issue;
    logic                  w_last_byte;
    logic                  w_timeout;
    logic                  w_err_set;
    logic [5:0]            w_raddr;
    logic [DW-1:0]         w_rdata;

    lcd_host_imgbuf u_imgbuf (
        .clk     (clk),
        .reset   (reset),
        .i_we    (w_px_fire),
        .i_waddr (r_pix_cnt),
        .i_wdata (px_data),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    // Next-state decode plus the handshake strobes, which are pure functions of state.
    always_comb begin
        w_next        = r_state;
        op_ready      = 1'b0;
        px_ready      = 1'b0;
        lcd_cmd_valid = 1'b0;
        w_op_fire     = 1'b0;
        w_px_fire     = 1'b0;
        w_issue       = 1'b0;
        w_last_byte   = 1'b0;
        w_timeout     = 1'b0;
        case (r_state)
            IDLE: begin
                op_ready  = 1'b1;
                w_op_fire = op_valid;
                if (op_valid && (op_cmd == CMD_LOAD)) begin
                    w_next = FILL;
                end else if (op_valid && op_is_valid(op_cmd)) begin
                    w_next = ISSUE;
                end else begin
                    w_next = IDLE;
                end
            end
            FILL: begin
                px_ready  = 1'b1;
                w_px_fire = px_valid;
                if (px_valid && (r_pix_cnt == PIX_LAST)) begin
                    w_next = ISSUE;
                end else begin
                    w_next = FILL;
                end
            end
            ISSUE: begin
                // The strobe is gated by the live busy level so it can never overlap busy.
                lcd_cmd_valid = !lcd_busy;
                w_issue       = !lcd_busy;
                if (lcd_busy) begin
                    w_next = ISSUE;
                end else if (r_cmd == CMD_LOAD) begin
                    w_next = STREAM;
                end else begin
                    w_next = WAIT_OUT;
                end
            end
            STREAM: begin
                if (r_pix_cnt == PIX_END) begin
                    w_next = WAIT_OUT;
                end else begin
                    w_next = STREAM;
                end
            end
            WAIT_OUT: begin
                w_last_byte = lcd_output_valid && (r_out_cnt == OUT_LAST);
                w_timeout   = !w_last_byte && (r_wait == WAIT_LAST);
                if (w_last_byte) begin
                    w_next = DONE;
                end else if (w_timeout) begin
                    w_next = IDLE;
                end else begin
                    w_next = WAIT_OUT;
                end
            end
            DONE: begin
                if (win_ready) begin
                    w_next = IDLE;
                end else begin
                    w_next = DONE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    assign w_err_set = (w_op_fire && !op_is_valid(op_cmd)) || w_timeout ||
                       (lcd_output_valid && (r_state != WAIT_OUT));
    assign w_raddr   = (r_state == STREAM) ? r_pix_cnt : 6'd0;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Sticky error flag; only reset clears it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_err <= 1'b0;
        end else if (w_err_set) begin
            r_err <= 1'b1;
        end
    end

    // Counters, command latch, pixel stream register and window packing.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cmd       <= 3'd0;
            r_pix_cnt   <= 6'd0;
            r_out_cnt   <= 4'd0;
            r_wait      <= 8'd0;
            r_datain    <= '0;
            r_win       <= '0;
            r_win_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_pix_cnt <= 6'd0;
                    if (w_op_fire && op_is_valid(op_cmd)) begin
                        r_cmd <= op_cmd;
                    end
                end
                FILL: begin
                    if (w_px_fire) begin
                        r_pix_cnt <= r_pix_cnt + 6'd1;
                    end
                end
                ISSUE: begin
                    if (w_issue) begin
                        r_out_cnt <= 4'd0;
                        r_wait    <= 8'd0;
                        // Preload pixel 0 so the stream starts right after the strobe cycle.
                        if (r_cmd == CMD_LOAD) begin
                            r_datain  <= w_rdata;
                            r_pix_cnt <= 6'd1;
                        end
                    end
                end
                STREAM: begin
                    if (r_pix_cnt == PIX_END) begin
                        r_datain <= '0;
                    end else begin
                        r_datain  <= w_rdata;
                        r_pix_cnt <= r_pix_cnt + 6'd1;
                    end
                end
                WAIT_OUT: begin
                    if (r_wait != 8'hFF) begin
                        r_wait <= r_wait + 8'd1;
                    end
                    if (w_timeout) begin
                        r_win <= '0;
                    end else if (lcd_output_valid) begin
                        for (int i = 0; i < WIN_PIX; i++) begin
                            if (r_out_cnt == 4'(i)) begin
                                r_win[i*DW +: DW] <= lcd_dataout;
                            end
                        end
                        r_out_cnt <= r_out_cnt + 4'd1;
                    end
                    if (w_last_byte) begin
                        r_win_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (win_ready) begin
                        r_win_valid <= 1'b0;
                    end
                end
                default: begin
                    r_win_valid <= 1'b0;
                end
            endcase
        end
    end

    assign lcd_cmd    = r_cmd;
    assign lcd_datain = r_datain;
    assign win_valid  = r_win_valid;
    assign win_data   = r_win;
    assign err        = r_err;

endmodule

// File: tb/tb_lcd_host.sv
// Randomized scoreboard bench for lcd_host with a behavioural 6x6 LCD controller model.
module tb_lcd_host;
    import lcd_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [2:0]  op_cmd = 3'd0;
    logic        px_valid = 1'b0;
    logic        px_ready;
    logic [7:0]  px_data = 8'd0;
    logic        win_valid;
    logic        win_ready = 1'b0;
    logic [71:0] win_data;
    logic        err;
    logic [2:0]  lcd_cmd;
    logic        lcd_cmd_valid;
    logic [7:0]  lcd_datain;
    logic [7:0]  lcd_dataout = 8'd0;
    logic        lcd_output_valid = 1'b0;
    logic        lcd_busy = 1'b0;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc = 0;

    logic [2:0]  exp_cmd [$];
    logic [7:0]  exp_pix [$];
    logic [71:0] exp_win [$];

    logic [7:0]  img [36];
    int          org_r = 2;
    int          org_c = 2;

    int          mon_stream_left;
    bit          mon_prev_cv;
    bit          mon_prev_wv;
    logic [71:0] mon_held;

    lcd_host dut (
        .clk              (clk),
        .reset            (reset),
        .op_valid         (op_valid),
        .op_ready         (op_ready),
        .op_cmd           (op_cmd),
        .px_valid         (px_valid),
        .px_ready         (px_ready),
        .px_data          (px_data),
        .win_valid        (win_valid),
        .win_ready        (win_ready),
        .win_data         (win_data),
        .err              (err),
        .lcd_cmd          (lcd_cmd),
        .lcd_cmd_valid    (lcd_cmd_valid),
        .lcd_datain       (lcd_datain),
        .lcd_dataout      (lcd_dataout),
        .lcd_output_valid (lcd_output_valid),
        .lcd_busy         (lcd_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Controller model: the window is a 3x3 block of the 6x6 image at (org_r, org_c).
    function automatic void model_op(input logic [2:0] c);
        case (c)
            CMD_LOAD:  begin org_r = 2; org_c = 2; end
            CMD_RIGHT: if (org_c < 3) org_c++;
            CMD_LEFT:  if (org_c > 0) org_c--;
            CMD_UP:    if (org_r > 0) org_r--;
            CMD_DOWN:  if (org_r < 3) org_r++;
            default:   ;
        endcase
    endfunction

    function automatic logic [71:0] model_win();
        logic [71:0] w;
        w = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                w[(i*3+j)*8 +: 8] = img[(org_r+i)*6 + org_c + j];
        return w;
    endfunction

    task automatic check_reset_vals(input string tag);
        chk({tag, "_op_ready"}, op_ready, 1);
        chk({tag, "_px_ready"}, px_ready, 0);
        chk({tag, "_cmd_valid"}, lcd_cmd_valid, 0);
        chk({tag, "_lcd_cmd"}, lcd_cmd, 0);
        chk({tag, "_datain"}, lcd_datain, 0);
        chk({tag, "_win_valid"}, win_valid, 0);
        chk({tag, "_win_data"}, win_data, 0);
        chk({tag, "_err"}, err, 0);
    endtask

    task automatic send_op(input logic [2:0] c);
        int n;
        n = 0;
        while (!op_ready && n < 200) begin
            tick(1);
            n++;
        end
        chk("op_ready_before_op", op_ready, 1);
        op_valid = 1'b1;
        op_cmd   = c;
        tick(1);
        op_valid = 1'b0;
    endtask

    task automatic fill();
        for (int i = 0; i < 36; i++) begin
            px_valid = 1'b0;
            tick($urandom_range(0, 2));
            px_valid = 1'b1;
            px_data  = img[i];
            chk("px_ready", px_ready, 1);
            tick(1);
        end
        px_valid = 1'b0;
    endtask

    task automatic wait_cmd();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            if (lcd_cmd_valid) ok = 1'b1;
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL cmd_timeout actual=none required=lcd_cmd_valid within 200 cycles");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic respond(input logic [71:0] w, input int nbytes);
        for (int j = 0; j < nbytes; j++) begin
            lcd_output_valid = 1'b0;
            tick($urandom_range(0, 2));
            lcd_output_valid = 1'b1;
            lcd_dataout      = w[j*8 +: 8];
            tick(1);
        end
        lcd_output_valid = 1'b0;
        lcd_dataout      = 8'd0;
    endtask

    task automatic accept_win(input int hold, output logic [71:0] seen);
        int n;
        n = 0;
        while (!win_valid && n < 100) begin
            tick(1);
            n++;
        end
        chk("win_valid_rise", win_valid, 1);
        seen = win_data;
        for (int i = 0; i < hold; i++) begin
            chk("op_ready_in_done", op_ready, 0);
            tick(1);
        end
        chk("win_valid_held", win_valid, 1);
        win_ready = 1'b1;
        tick(1);
        win_ready = 1'b0;
        chk("win_valid_drop", win_valid, 0);
        chk("op_ready_after_done", op_ready, 1);
    endtask

    task automatic transact(input logic [2:0] c, input int busy_cyc, input int hold,
                            input bit busy_stream, output logic [71:0] seen);
        logic [71:0] w;
        model_op(c);
        w = model_win();
        exp_cmd.push_back(c);
        if (c == CMD_LOAD)
            for (int i = 0; i < 36; i++) exp_pix.push_back(img[i]);
        exp_win.push_back(w);
        lcd_busy = (busy_cyc > 0);
        send_op(c);
        if (c == CMD_LOAD) fill();
        for (int i = 0; i < busy_cyc; i++) begin
            chk("cv_low_while_busy", lcd_cmd_valid, 0);
            tick(1);
        end
        lcd_busy = 1'b0;
        wait_cmd();
        if (c == CMD_LOAD) begin
            for (int i = 0; i < 36; i++) begin
                lcd_busy = busy_stream ? 1'($urandom_range(0, 1)) : 1'b0;
                tick(1);
            end
        end
        lcd_busy = 1'b0;
        respond(w, 9);
        accept_win(hold, seen);
    endtask

    // Monitor: pops expectations whenever the DUT strobes a command, streams, or presents a window.
    initial begin
        mon_stream_left = 0;
        mon_prev_cv     = 1'b0;
        mon_prev_wv     = 1'b0;
        mon_held        = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                mon_stream_left = 0;
                mon_prev_cv     = 1'b0;
                mon_prev_wv     = 1'b0;
            end else begin
                if (lcd_cmd_valid) begin
                    chk("cmd_not_busy", lcd_busy, 0);
                    chk("cmd_not_back_to_back", mon_prev_cv, 0);
                    if (exp_cmd.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_cmd actual=%0d required=none", lcd_cmd);
                    end else begin
                        logic [2:0] e;
                        e = exp_cmd.pop_front();
                        chk("lcd_cmd", lcd_cmd, e);
                        if (e == CMD_LOAD) mon_stream_left = 36;
                    end
                end else if (mon_stream_left > 0) begin
                    if (exp_pix.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL stream_extra actual=%0h required=none", lcd_datain);
                    end else begin
                        chk("lcd_datain", lcd_datain, exp_pix.pop_front());
                    end
                    mon_stream_left--;
                end else begin
                    chk("datain_idle", lcd_datain, 0);
                end
                if (win_valid && !mon_prev_wv) begin
                    if (exp_win.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_win actual=%0h required=none", win_data);
                    end else begin
                        chk("win_data", win_data, exp_win.pop_front());
                    end
                    mon_held = win_data;
                end else if (win_valid) begin
                    chk("win_stable", win_data, mon_held);
                end
                mon_prev_cv = lcd_cmd_valid;
                mon_prev_wv = win_valid;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [71:0] seen;
        logic [2:0]  c;
        int unsigned c0;
        int          n;

        // Reset values.
        tick(2);
        check_reset_vals("reset");
        reset = 1'b1;
        tick(1);

        // Load 0..35, window held 20 cycles in DONE.
        for (int i = 0; i < 36; i++) img[i] = 8'(i);
        transact(CMD_LOAD, 0, 20, 1'b0, seen);
        chk("load_win_literal", seen, 72'h1c1b1a161514100f0e);

        // Right while busy for 10 cycles.
        transact(CMD_RIGHT, 10, 0, 1'b0, seen);
        chk("err_after_right", err, 0);

        // Random ops, random images, random busy.
        for (int t = 0; t < 8; t++) begin
            c = 3'($urandom_range(0, 5));
            if (c == CMD_LOAD)
                for (int i = 0; i < 36; i++) img[i] = 8'($urandom_range(0, 255));
            transact(c, $urandom_range(0, 4), $urandom_range(0, 3), 1'b1, seen);
        end
        chk("err_after_random", err, 0);

        // Reset in the middle of streaming, then a full Load.
        for (int i = 0; i < 36; i++) img[i] = 8'($urandom_range(0, 255));
        model_op(CMD_LOAD);
        exp_cmd.push_back(CMD_LOAD);
        for (int i = 0; i < 36; i++) exp_pix.push_back(img[i]);
        exp_win.push_back(model_win());
        send_op(CMD_LOAD);
        fill();
        wait_cmd();
        tick(20);
        reset = 1'b0;
        #1;
        check_reset_vals("midreset");
        exp_cmd.delete();
        exp_pix.delete();
        exp_win.delete();
        tick(3);
        reset = 1'b1;
        tick(1);
        for (int i = 0; i < 36; i++) img[i] = 8'($urandom_range(0, 255));
        transact(CMD_LOAD, 2, 1, 1'b0, seen);
        chk("err_after_midreset", err, 0);

        // Illegal op code.
        send_op(3'd7);
        chk("op7_err", err, 1);
        for (int i = 0; i < 10; i++) begin
            chk("op7_op_ready", op_ready, 1);
            chk("op7_no_cmd", lcd_cmd_valid, 0);
            tick(1);
        end

        // Timeout: only 5 of 9 window bytes arrive.
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(1);
        chk("err_cleared_by_reset", err, 0);
        exp_cmd.push_back(CMD_REFLASH);
        send_op(CMD_REFLASH);
        wait_cmd();
        c0 = cyc;
        respond(model_win(), 5);
        n = 0;
        while (!err && n < 400) begin
            tick(1);
            n++;
        end
        chk("timeout_cycles", 72'(cyc - c0), 255);
        chk("timeout_err", err, 1);
        chk("timeout_op_ready", op_ready, 1);
        chk("timeout_win_valid", win_valid, 0);
        tick(5);

        chk("pending_cmd", exp_cmd.size(), 0);
        chk("pending_pix", exp_pix.size(), 0);
        chk("pending_win", exp_win.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lcd_host.md
Name: lcd_host

Overview:
- Host-side driver for the 6x6-image LCD controller interface; it is the initiator end of the cmd/datain/dataout/busy protocol.
- Accepts high-level ops from a system-side op port and buffers the 36 image bytes for a Load.
- Issues each LCD command with a one-cycle cmd_valid while the controller is not busy, streams the image on consecutive cycles, then collects the 9-byte display window and hands it up as one packed word.

Parameters:
- DW, 8, pixel width in bits.
- IMG_PIX, 36, pixels per image load.
- WIN_PIX, 9, pixels per display window.
- TIMEOUT, 255, max cycles in WAIT_OUT before abort.

Ports:
- clk  in  1  single clock, all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- op_valid  in  1  system op request.
- op_ready  out  1  op accepted when op_valid&op_ready at a clock edge.
- op_cmd  in  3  0 Reflash, 1 Load, 2 Right, 3 Left, 4 Up, 5 Down.
- px_valid  in  1  image byte valid (used only in FILL).
- px_ready  out  1  image byte accepted.
- px_data  in  DW  image byte, raster order.
- win_valid  out  1  collected window available.
- win_ready  in  1  window consumed.
- win_data  out  DW*WIN_PIX  window bytes, first received at bits [7:0].
- err  out  1  sticky error flag.
- lcd_cmd  out  3  command to controller.
- lcd_cmd_valid  out  1  command strobe.
- lcd_datain  out  DW  image byte to controller.
- lcd_dataout  in  DW  window byte from controller.
- lcd_output_valid  in  1  lcd_dataout valid.
- lcd_busy  in  1  controller busy.

Behaviour:
- Reset (reset=0, async): state IDLE; counters 0; lcd_cmd_valid=0, lcd_cmd=0, lcd_datain=0; win_valid=0, win_data=0, err=0. Outputs hold these values until the first edge after release.
- op_ready=1 only in IDLE. px_ready=1 only in FILL. Both are combinational from state.
- States:
  - IDLE:
    - Load accepted -> FILL, pix_cnt=0.
    - Op 0/2..5 accepted -> ISSUE, latch cmd.
    - op_cmd 6/7 accepted -> set err, stay IDLE, no LCD activity.
  - FILL: each px_valid&px_ready writes buf[pix_cnt] and increments pix_cnt. At pix_cnt reaching 36 -> ISSUE. px_valid gaps allowed.
  - ISSUE: wait while lcd_busy=1. On the first cycle with lcd_busy=0, drive lcd_cmd_valid=1 for exactly one cycle. Then Load -> STREAM, others -> WAIT_OUT.
  - STREAM: starting the cycle after the cmd_valid cycle, lcd_datain=buf[k] for k=0..35 on 36 consecutive cycles, no gaps, then -> WAIT_OUT. lcd_datain returns to 0 afterwards.
  - WAIT_OUT: each cycle with lcd_output_valid=1 writes lcd_dataout into win byte out_cnt, out_cnt++. After the 9th byte -> DONE with win_valid=1 the next cycle.
  - DONE: win_data stable while win_valid=1. win_valid&win_ready -> win_valid=0, IDLE.
- lcd_cmd_valid is never asserted while lcd_busy=1 and never for two consecutive cycles.
- Timeout: a wait counter runs in WAIT_OUT. If it reaches TIMEOUT before 9 bytes arrive, set err, discard the partial window, -> IDLE, and win_valid is not asserted.
- lcd_output_valid outside WAIT_OUT: data ignored, err set.
- lcd_busy rising during STREAM does not stall streaming.
- A simultaneous last FILL byte and lcd_busy=0 still needs one ISSUE cycle before cmd_valid; there is no same-cycle issue.
- Counters: pix_cnt 6 bits, out_cnt 4 bits, wait counter 8 bits saturating. No wrap is possible by construction.
- err is cleared only by reset.
- Reset mid-operation aborts immediately. The buffer content is don't-care afterwards; a new Load refills all 36 bytes.

Decomposition:
- Shared package lcd_pkg:
  - command encodings CMD_REFLASH..CMD_DOWN (0..5);
  - IMG_PIX=36, WIN_PIX=9, DW=8;
  - host state enum {IDLE, FILL, ISSUE, STREAM, WAIT_OUT, DONE}.
- One sub-module, lcd_host_imgbuf: 36xDW register file with write port (FILL) and indexed read port (STREAM).
- FSM, counters and window packing stay in lcd_host.

Test Plan:
- Load, px_data=0..35 with a random px_valid gap; behavioural controller returns 14,15,16,20,21,22,26,27,28:
  - one lcd_cmd_valid with lcd_cmd=1;
  - lcd_datain 0..35 on 36 consecutive cycles;
  - win_data={28,27,26,22,21,20,16,15,14}, win_valid held until win_ready.
- Right op while lcd_busy held 1 for 10 cycles -> lcd_cmd_valid stays 0 for those 10 cycles, then one pulse with lcd_cmd=2; window captured, err=0.
- Reflash op, controller emits only 5 output_valid bytes -> after TIMEOUT=255 cycles err=1, state IDLE, win_valid never 1, op_ready=1.
- op_cmd=7 -> accepted, err=1, no lcd_cmd_valid, op_ready stays 1.
- reset=0 asserted at STREAM k=20 -> all outputs at reset values immediately; after release a full Load completes and win_data matches the model.
- win_ready held 0 for 20 cycles in DONE -> win_data constant, op_ready=0, no new lcd_cmd_valid.
